// File: rtl/uart_dbus_if.sv
// Per-block data-bus channel between the 8-way bus decoder (master) and the UART slave.
interface uart_dbus_if #(
   parameter int DW = 16,
   parameter int AW = 13
);
   logic [DW-1:0] din;
   logic [AW-1:0] addr;
   logic          we;
   logic [DW-1:0] dout;

   modport master (output din, output addr, output we, input dout);
   modport slave  (input din, input addr, input we, output dout);
endinterface

// File: rtl/uart_dbus.sv
// UART bus slave: 8N1 TX through a small FIFO, single-byte RX holding register, baud divisor, level irq.
// Optional internal loopback (CTRL bit4) is built only when UART_LOOPBACK_EN is defined.
module uart_dbus #(
   parameter int          DW          = 16,
   parameter int          AW          = 13,
   parameter int          FIFO_DEPTH  = 4,
   parameter logic [15:0] DEFAULT_DIV = 16'd15
) (
   input  logic        clk,
   input  logic        rst_n,
   uart_dbus_if.slave  bus,
   input  logic        uart_rx,
   output logic        uart_tx,
   output logic        irq
);
   localparam int           PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [PW:0]  DEPTH_C = (PW+1)'(FIFO_DEPTH);
   localparam logic [PW:0]  CNT_Z   = {(PW+1){1'b0}};

   typedef enum logic [1:0] {TIDLE, TSTART, TDATA, TSTOP} tx_state_e;
   typedef enum logic [2:0] {RIDLE, RSTART, RDATA, RSTOP, RWAIT} rx_state_e;

   logic [15:0]   baud_q;
   logic          tx_en_q, rx_en_q, rx_irq_en_q, txe_irq_en_q;
   logic          lb_s;
   logic [7:0]    fifo_mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [PW:0]   cnt_q;
   tx_state_e     tx_st_q;
   logic [7:0]    tx_shift_q;
   logic [2:0]    tx_bit_q;
   logic [15:0]   tx_cnt_q;
   logic          tx_line_q;
   rx_state_e     rx_st_q;
   logic [1:0]    rx_sync_q;
   logic          rx_prev_q;
   logic [7:0]    rx_shift_q, rx_data_q;
   logic [2:0]    rx_bit_q;
   logic [15:0]   rx_cnt_q;
   logic          rx_valid_q, rx_ovf_q, tx_ovf_q, frm_err_q;
   logic [DW-1:0] dout_q;
   logic          irq_q;

   logic [1:0]    a_s;
   logic          wr_data_s, wr_stat_s, wr_baud_s, wr_ctrl_s;
   logic [15:0]   eff_div_s, half_m1_s, rd_mux_s;
   logic [16:0]   bit_clks_s;
   logic          pop_s, push_ok_s, tx_busy_s, tx_full_s, rx_in_s, rx_done_s, rx_ferr_s;
   logic          unused_s;

   assign a_s       = bus.addr[1:0];
   assign unused_s  = ^bus.addr[AW-1:2];
   assign wr_data_s = bus.we & (a_s == 2'd0);
   assign wr_stat_s = bus.we & (a_s == 2'd1);
   assign wr_baud_s = bus.we & (a_s == 2'd2);
   assign wr_ctrl_s = bus.we & (a_s == 2'd3);
   assign tx_busy_s = (tx_st_q != TIDLE);
   assign tx_full_s = (cnt_q == DEPTH_C);

`ifdef UART_LOOPBACK_EN
   logic lb_q;
   assign lb_s    = lb_q;
   assign rx_in_s = lb_q ? tx_line_q : rx_sync_q[1];
   assign uart_tx = tx_line_q | lb_q;
`else
   assign lb_s    = 1'b0;
   assign rx_in_s = rx_sync_q[1];
   assign uart_tx = tx_line_q;
`endif

   assign rx_done_s = (rx_st_q == RSTOP) && (rx_cnt_q == 16'd0) && rx_in_s;
   assign rx_ferr_s = (rx_st_q == RSTOP) && (rx_cnt_q == 16'd0) && !rx_in_s;
   assign bus.dout  = dout_q;
   assign irq       = irq_q;

   // Divisors below 3 are clamped; the RX start-bit check waits half a bit time.
   always_comb begin
      eff_div_s  = (baud_q < 16'd3) ? 16'd3 : baud_q;
      bit_clks_s = {1'b0, eff_div_s} + 17'd1;
      half_m1_s  = 16'((bit_clks_s >> 1) - 17'd1);
   end

   always_comb begin
      pop_s     = 1'b0;
      push_ok_s = 1'b0;
      if (tx_en_q && (cnt_q != CNT_Z) &&
          ((tx_st_q == TIDLE) || ((tx_st_q == TSTOP) && (tx_cnt_q == 16'd0)))) begin
         pop_s = 1'b1;
      end else begin
         pop_s = 1'b0;
      end
      push_ok_s = wr_data_s && ((cnt_q != DEPTH_C) || pop_s);
   end

   always_comb begin
      rd_mux_s = 16'h0000;
      case (a_s)
         2'd0:    rd_mux_s = {8'h00, rx_data_q};
         2'd1:    rd_mux_s = {10'd0, frm_err_q, rx_ovf_q, tx_ovf_q, tx_busy_s, tx_full_s, rx_valid_q};
         2'd2:    rd_mux_s = baud_q;
         2'd3:    rd_mux_s = {11'd0, lb_s, txe_irq_en_q, rx_irq_en_q, rx_en_q, tx_en_q};
         default: rd_mux_s = 16'h0000;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         fifo_mem[wr_ptr_q] <= bus.din[7:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= {PW{1'b0}};
         rd_ptr_q <= {PW{1'b0}};
         cnt_q    <= CNT_Z;
      end else begin
         if (push_ok_s) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop_s)     rd_ptr_q <= rd_ptr_q + PW'(1);
         case ({push_ok_s, pop_s})
            2'b10:   cnt_q <= cnt_q + (PW+1)'(1);
            2'b01:   cnt_q <= cnt_q - (PW+1)'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   // TX frame: a stop bit that ends with data pending goes straight into the next start bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_st_q    <= TIDLE;
         tx_line_q  <= 1'b1;
         tx_shift_q <= 8'h00;
         tx_bit_q   <= 3'd0;
         tx_cnt_q   <= 16'd0;
      end else begin
         case (tx_st_q)
            TIDLE: begin
               if (pop_s) begin
                  tx_st_q    <= TSTART;
                  tx_shift_q <= fifo_mem[rd_ptr_q];
                  tx_line_q  <= 1'b0;
                  tx_cnt_q   <= eff_div_s;
               end
            end
            TSTART: begin
               if (tx_cnt_q == 16'd0) begin
                  tx_st_q   <= TDATA;
                  tx_line_q <= tx_shift_q[0];
                  tx_bit_q  <= 3'd0;
                  tx_cnt_q  <= eff_div_s;
               end else begin
                  tx_cnt_q <= tx_cnt_q - 16'd1;
               end
            end
            TDATA: begin
               if (tx_cnt_q == 16'd0) begin
                  tx_cnt_q <= eff_div_s;
                  if (tx_bit_q == 3'd7) begin
                     tx_st_q   <= TSTOP;
                     tx_line_q <= 1'b1;
                  end else begin
                     tx_bit_q   <= tx_bit_q + 3'd1;
                     tx_shift_q <= tx_shift_q >> 1;
                     tx_line_q  <= tx_shift_q[1];
                  end
               end else begin
                  tx_cnt_q <= tx_cnt_q - 16'd1;
               end
            end
            TSTOP: begin
               if (tx_cnt_q == 16'd0) begin
                  if (pop_s) begin
                     tx_st_q    <= TSTART;
                     tx_shift_q <= fifo_mem[rd_ptr_q];
                     tx_line_q  <= 1'b0;
                     tx_cnt_q   <= eff_div_s;
                  end else begin
                     tx_st_q <= TIDLE;
                  end
               end else begin
                  tx_cnt_q <= tx_cnt_q - 16'd1;
               end
            end
            default: begin
               tx_st_q   <= TIDLE;
               tx_line_q <= 1'b1;
            end
         endcase
      end
   end

   // RX frame: a high line at mid-start-bit is a glitch; a low stop bit waits for idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_sync_q  <= 2'b11;
         rx_prev_q  <= 1'b1;
         rx_st_q    <= RIDLE;
         rx_shift_q <= 8'h00;
         rx_bit_q   <= 3'd0;
         rx_cnt_q   <= 16'd0;
      end else begin
         rx_sync_q <= {rx_sync_q[0], uart_rx};
         rx_prev_q <= rx_in_s;
         case (rx_st_q)
            RIDLE: begin
               if (rx_en_q && rx_prev_q && !rx_in_s) begin
                  rx_st_q  <= RSTART;
                  rx_cnt_q <= half_m1_s;
               end
            end
            RSTART: begin
               if (rx_cnt_q == 16'd0) begin
                  if (rx_in_s) begin
                     rx_st_q <= RIDLE;
                  end else begin
                     rx_st_q  <= RDATA;
                     rx_bit_q <= 3'd0;
                     rx_cnt_q <= eff_div_s;
                  end
               end else begin
                  rx_cnt_q <= rx_cnt_q - 16'd1;
               end
            end
            RDATA: begin
               if (rx_cnt_q == 16'd0) begin
                  rx_shift_q <= {rx_in_s, rx_shift_q[7:1]};
                  rx_cnt_q   <= eff_div_s;
                  if (rx_bit_q == 3'd7) begin
                     rx_st_q <= RSTOP;
                  end else begin
                     rx_bit_q <= rx_bit_q + 3'd1;
                  end
               end else begin
                  rx_cnt_q <= rx_cnt_q - 16'd1;
               end
            end
            RSTOP: begin
               if (rx_cnt_q == 16'd0) begin
                  rx_st_q <= rx_in_s ? RIDLE : RWAIT;
               end else begin
                  rx_cnt_q <= rx_cnt_q - 16'd1;
               end
            end
            RWAIT: begin
               if (rx_in_s) rx_st_q <= RIDLE;
            end
            default: rx_st_q <= RIDLE;
         endcase
      end
   end

   // Hardware sets take priority over write-1-to-clear in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         baud_q       <= DEFAULT_DIV;
         tx_en_q      <= 1'b1;
         rx_en_q      <= 1'b1;
         rx_irq_en_q  <= 1'b0;
         txe_irq_en_q <= 1'b0;
`ifdef UART_LOOPBACK_EN
         lb_q         <= 1'b0;
`endif
         rx_data_q    <= 8'h00;
         rx_valid_q   <= 1'b0;
         rx_ovf_q     <= 1'b0;
         tx_ovf_q     <= 1'b0;
         frm_err_q    <= 1'b0;
      end else begin
         if (wr_baud_s) baud_q <= bus.din[15:0];
         if (wr_ctrl_s) begin
            tx_en_q      <= bus.din[0];
            rx_en_q      <= bus.din[1];
            rx_irq_en_q  <= bus.din[2];
            txe_irq_en_q <= bus.din[3];
`ifdef UART_LOOPBACK_EN
            lb_q         <= bus.din[4];
`endif
         end
         if (rx_done_s) rx_data_q <= rx_shift_q;
         rx_valid_q <= rx_done_s | (rx_valid_q & ~(wr_stat_s & bus.din[0]));
         tx_ovf_q   <= (wr_data_s & ~push_ok_s) | (tx_ovf_q & ~(wr_stat_s & bus.din[3]));
         rx_ovf_q   <= (rx_done_s & rx_valid_q) | (rx_ovf_q & ~(wr_stat_s & bus.din[4]));
         frm_err_q  <= rx_ferr_s | (frm_err_q & ~(wr_stat_s & bus.din[5]));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout_q <= {DW{1'b0}};
         irq_q  <= 1'b0;
      end else begin
         dout_q <= rd_mux_s;
         irq_q  <= (rx_irq_en_q & rx_valid_q) | (txe_irq_en_q & (cnt_q == CNT_Z) & ~tx_busy_s);
      end
   end
endmodule

// File: tb/tb_uart_dbus.sv
// Self-checking bench for uart_dbus: bus-register shadow model plus a serial-waveform model for TX.
module tb_uart_dbus;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic uart_rx = 1'b1;
   logic uart_tx, irq;

   uart_dbus_if #(.DW(16), .AW(13)) bus();

   uart_dbus #(.DW(16), .AW(13), .FIFO_DEPTH(4), .DEFAULT_DIV(16'd15)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus), .uart_rx(uart_rx), .uart_tx(uart_tx), .irq(irq)
   );

   always #5 clk = ~clk;

`ifdef UART_LOOPBACK_EN
   localparam logic [15:0] CTRL_MASK = 16'h001F;
`else
   localparam logic [15:0] CTRL_MASK = 16'h000F;
`endif

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;
   logic [15:0] m_baud, m_ctrl;
   logic [7:0]  m_rx_data;
   logic        m_rx_valid, m_rx_ovf, m_tx_ovf, m_frm;
   logic [7:0]  exp_q[$];
   bit          in_frame = 1'b0;
   int          fk, fbt;
   logic [9:0]  fbits;

   function automatic int bitclks(input logic [15:0] b);
      return ((b < 16'd3) ? 3 : int'(b)) + 1;
   endfunction

   function automatic logic [15:0] exp_status();
      return {10'd0, m_frm, m_rx_ovf, m_tx_ovf, 1'b0, 1'b0, m_rx_valid};
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_baud = 16'h000F; m_ctrl = 16'h0003; m_rx_data = 8'h00;
      m_rx_valid = 1'b0; m_rx_ovf = 1'b0; m_tx_ovf = 1'b0; m_frm = 1'b0;
      exp_q.delete();
      in_frame = 1'b0;
   endtask

   // Per-cycle comparison: BAUD/CTRL readback against the shadow, uart_tx against the expected frame.
   always @(posedge clk) begin
      #1;
      if (chk_en) begin
         if (bus.addr[1:0] == 2'd2) chk("baud_rd", bus.dout, m_baud);
         else if (bus.addr[1:0] == 2'd3) chk("ctrl_rd", bus.dout, m_ctrl);
         if (in_frame) begin
            chk("tx_bit", {15'd0, uart_tx}, {15'd0, fbits[fk / fbt]});
            fk++;
            if (fk == 10 * fbt) in_frame = 1'b0;
         end else if (uart_tx == 1'b0) begin
            if (exp_q.size() == 0) begin
               chk("tx_unexpected_start", {15'd0, uart_tx}, 16'd1);
            end else begin
               fbits    = {1'b1, exp_q.pop_front(), 1'b0};
               fbt      = bitclks(m_baud);
               chk("tx_bit", {15'd0, uart_tx}, {15'd0, fbits[0]});
               fk       = 1;
               in_frame = 1'b1;
            end
         end
      end
   end

   task automatic bus_cycle(input logic [1:0] a, input logic [15:0] d, input bit w);
      @(negedge clk);
      bus.addr = {11'($urandom), a};
      bus.din  = d;
      bus.we   = w;
      @(posedge clk);
      #2;
      if (w) begin
         case (a)
            2'd1: begin
               if (d[0]) m_rx_valid = 1'b0;
               if (d[3]) m_tx_ovf = 1'b0;
               if (d[4]) m_rx_ovf = 1'b0;
               if (d[5]) m_frm = 1'b0;
            end
            2'd2:    m_baud = d;
            2'd3:    m_ctrl = d & CTRL_MASK;
            default: ;
         endcase
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         bus.we = 1'b0;
      end
   endtask

   task automatic wr(input logic [1:0] a, input logic [15:0] d);
      bus_cycle(a, d, 1'b1);
      idle(1);
   endtask

   task automatic rd_chk(input string name, input logic [1:0] a, input logic [15:0] exp);
      @(negedge clk);
      bus.we   = 1'b0;
      bus.addr = {11'($urandom), a};
      @(posedge clk);
      #1;
      chk(name, bus.dout, exp);
   endtask

   task automatic send_rx(input logic [7:0] b, input bit stop, input int bt);
      logic [9:0] f;
      f = {stop, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         uart_rx = f[i];
         repeat (bt - 1) @(negedge clk);
      end
      @(negedge clk);
      uart_rx = 1'b1;
   endtask

   task automatic rx_model(input logic [7:0] b, input bit stop);
      if (stop) begin
         if (m_rx_valid) m_rx_ovf = 1'b1;
         m_rx_valid = 1'b1;
         m_rx_data  = b;
      end else begin
         m_frm = 1'b1;
      end
   endtask

   task automatic wait_tx_done();
      int n = 0;
      while ((exp_q.size() != 0 || in_frame) && n < 20000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20000) chk("tx_done_timeout", 16'(n), 16'd0);
      idle(3);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [9:0]  lit;
      logic [7:0]  b;
      logic [15:0] bd;
      int          n, nb, bt, lb_bad;

      bus.we = 1'b0; bus.addr = 13'd0; bus.din = 16'h0000;
      model_reset();
      repeat (3) @(negedge clk);
      chk("rst_tx", {15'd0, uart_tx}, 16'd1);
      chk("rst_irq", {15'd0, irq}, 16'd0);
      chk("rst_dout", bus.dout, 16'h0000);
      rst_n  = 1'b1;
      chk_en = 1'b1;
      rd_chk("rst_baud", 2'd2, 16'h000F);
      rd_chk("rst_ctrl", 2'd3, 16'h0003);
      rd_chk("rst_status", 2'd1, 16'h0000);

      // Single frame 0xA5 at 16 clocks per bit, checked against a literal bit pattern.
      lit = 10'b1101001010;
      exp_q.push_back(8'hA5);
      wr(2'd0, 16'h00A5);
      bus.addr = 13'd1;
      n = 0;
      while (uart_tx !== 1'b0 && n < 20) begin
         @(posedge clk); #1; n++;
      end
      chk("a5_start_seen", {15'd0, uart_tx}, 16'd0);
      for (int k = 0; k < 160; k++) begin
         chk("a5_bit", {15'd0, uart_tx}, {15'd0, lit[k / 16]});
         if (k > 0) chk("a5_busy", {15'd0, bus.dout[2]}, 16'd1);
         @(posedge clk); #1;
      end
      chk("a5_stop_idle", {15'd0, uart_tx}, 16'd1);
      wait_tx_done();

      // Six back-to-back writes: one pops at once, four fill the FIFO, the sixth overflows.
      for (int i = 0; i < 6; i++) begin
         if (i < 5) exp_q.push_back(8'(8'h11 + i));
         bus_cycle(2'd0, 16'(16'h0011 + i), 1'b1);
      end
      m_tx_ovf = 1'b1;
      rd_chk("burst_status", 2'd1, 16'h000E);
      wait_tx_done();
      rd_chk("ovf_status", 2'd1, 16'h0008);
      wr(2'd1, 16'h0008);
      rd_chk("ovf_cleared", 2'd1, 16'h0000);

      // Receive, then overrun, then framing error and glitch rejection.
      send_rx(8'h3C, 1'b1, 16); rx_model(8'h3C, 1'b1); idle(4);
      rd_chk("rx_data_3c", 2'd0, 16'h003C);
      rd_chk("rx_status1", 2'd1, 16'h0001);
      send_rx(8'h7E, 1'b1, 16); rx_model(8'h7E, 1'b1); idle(4);
      rd_chk("rx_data_7e", 2'd0, 16'h007E);
      rd_chk("rx_ovf_status", 2'd1, 16'h0011);
      wr(2'd1, 16'h0011);
      rd_chk("rx_cleared", 2'd1, exp_status());
      send_rx(8'hA0, 1'b0, 16); rx_model(8'hA0, 1'b0); idle(20);
      rd_chk("frm_status", 2'd1, 16'h0020);
      wr(2'd1, 16'h0020);
      @(negedge clk); uart_rx = 1'b0;
      repeat (4) @(negedge clk);
      uart_rx = 1'b1;
      idle(200);
      rd_chk("glitch_status", 2'd1, 16'h0000);
      rd_chk("glitch_data", 2'd0, 16'h007E);

      // Interrupt sources.
      wr(2'd3, 16'h0007);
      chk("irq_off", {15'd0, irq}, 16'd0);
      send_rx(8'h5A, 1'b1, 16); rx_model(8'h5A, 1'b1); idle(4);
      chk("irq_rx", {15'd0, irq}, 16'd1);
      wr(2'd1, 16'h0001);
      idle(2);
      chk("irq_rx_cleared", {15'd0, irq}, 16'd0);
      wr(2'd3, 16'h000B);
      idle(2);
      chk("irq_txe", {15'd0, irq}, 16'd1);
      wr(2'd3, 16'h0003);

      // Randomised divisors (including clamped values), TX bursts and RX bytes.
      for (int it = 0; it < 8; it++) begin
         bd = 16'($urandom_range(0, 20));
         wr(2'd2, bd);
         nb = $urandom_range(1, 4);
         for (int i = 0; i < nb; i++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            bus_cycle(2'd0, {8'h00, b}, 1'b1);
         end
         idle(1);
         wait_tx_done();
         bt = bitclks(bd);
         nb = $urandom_range(1, 2);
         for (int i = 0; i < nb; i++) begin
            b = 8'($urandom);
            send_rx(b, 1'b1, bt); rx_model(b, 1'b1); idle(4);
         end
         rd_chk("rnd_rx_data", 2'd0, {8'h00, m_rx_data});
         rd_chk("rnd_status", 2'd1, exp_status());
         wr(2'd1, 16'h0039);
      end

      // Clearing tx_en mid-frame completes the byte and holds the rest.
      wr(2'd2, 16'h000F);
      exp_q.push_back(8'h81); exp_q.push_back(8'h42);
      bus_cycle(2'd0, 16'h0081, 1'b1);
      bus_cycle(2'd0, 16'h0042, 1'b1);
      idle(50);
      wr(2'd3, 16'h0002);
      n = 0;
      while ((exp_q.size() != 1 || in_frame) && n < 1000) begin
         @(negedge clk); n++;
      end
      idle(40);
      chk("txen_hold_q", 16'(exp_q.size()), 16'd1);
      chk("txen_hold_line", {15'd0, uart_tx}, 16'd1);
      rd_chk("txen_hold_status", 2'd1, 16'h0000);
      wr(2'd3, 16'h0003);
      wait_tx_done();

`ifdef UART_LOOPBACK_EN
      wr(2'd3, 16'h0013);
      wr(2'd0, 16'h0055);
      lb_bad = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (uart_tx !== 1'b1) lb_bad++;
      end
      chk("lb_tx_high", 16'(lb_bad), 16'd0);
      rx_model(8'h55, 1'b1);
      rd_chk("lb_rx_data", 2'd0, 16'h0055);
      wr(2'd1, 16'h0039);
      wr(2'd3, 16'h0003);
`endif

      // Reset mid-frame returns the line high immediately and restores defaults.
      wr(2'd2, 16'h0009);
      exp_q.push_back(8'h00);
      wr(2'd0, 16'h0000);
      idle(30);
      chk("pre_rst_low", {15'd0, uart_tx}, 16'd0);
      chk_en = 1'b0;
      rst_n  = 1'b0;
      #1;
      chk("midrst_tx", {15'd0, uart_tx}, 16'd1);
      chk("midrst_irq", {15'd0, irq}, 16'd0);
      model_reset();
      repeat (2) @(negedge clk);
      rst_n  = 1'b1;
      chk_en = 1'b1;
      rd_chk("post_rst_baud", 2'd2, 16'h000F);
      rd_chk("post_rst_status", 2'd1, 16'h0000);
      idle(100);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
